// File: rtl/dpram_block_reader.sv
// Streams a block of consecutive RAM words onto a valid/ready output through a 2-entry buffer.
// The first word appears 3 cycles after start; back-pressure is absorbed by read credits, so no word is lost.
module dpram_block_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] next_addr, last_addr;
  logic [ADDR_W:0]   len_q, issued, delivered;
  logic              rd_pend;
  logic [DATA_W-1:0] buf_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop, issue;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = buf_mem[rd_ptr];
  assign out_last  = out_valid && ((delivered + 1'b1) == len_q);
  assign busy      = (state != IDLE);

  // Words already buffered plus the one in flight must leave room for the next read.
  assign occ   = {1'b0, count} + {2'b00, rd_pend};
  assign issue = (state == READ) && (issued != len_q) && ((occ - {2'b00, pop}) < 3'd2);

  assign ram_rd_en   = issue;
  assign ram_rd_addr = issue ? next_addr : last_addr;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? DONE : READ;
      end
      READ: begin
        if (issue && ((issued + 1'b1) == len_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!rd_pend && ((count == 2'd0) || (count == 2'd1 && pop))) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      next_addr <= '0;
      last_addr <= '0;
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      rd_pend   <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= issue;
      if (state == IDLE && start) begin
        next_addr <= start_addr;
        len_q     <= length;
        issued    <= '0;
        delivered <= '0;
      end
      if (issue) begin
        next_addr <= next_addr + 1'b1;
        last_addr <= next_addr;
        issued    <= issued + 1'b1;
      end
      // RAM data lands one cycle after the read was issued.
      if (rd_pend) begin
        buf_mem[wr_ptr] <= ram_rd_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        delivered <= delivered + 1'b1;
      end
      count <= count + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

endmodule
